fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_wr_arb_rr_pick.sv | 32 +++
 rtl/fifo_wr_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//   state_t  : arbiter FSM state encoding (IDLE=0, GRANT=1)
//   STAT_MAX : saturation value for the optional per-requester beat counters
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, shared by the read and write arbiters.
// Searches req starting one position after last, wrapping modulo NREQ.
//   req  : request vector, one bit per requester
//   last : index of the previous winner
//   idx  : selected requester (0 when none)
//   any  : high when at least one request bit is set
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IW'((32'(last) + off) % NREQ);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter merging NREQ AXI-Stream writers into one FIFO write port.
// A grant lasts until the holder sends tlast or BURST beats, then one IDLE cycle follows.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   i_req_tvalid/tlast: per-requester valid / end-of-packet
//   i_req_tdata       : packed requester data, requester k at [k*DLEN +: DLEN]
//   o_req_tready      : per-requester ready (only the grant holder can see ready)
//   o_wr_tvalid/tdata : stream toward the FIFO write port
//   i_wr_tready       : FIFO not full
//   o_grant_id        : current (or most recent) grant holder
//   o_busy            : high while a grant is held
// Optional macro FIFO_WR_ARB_STATS_EN adds o_beat_cnt (NREQ x 16-bit saturating
// per-requester transfer counters).
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DLEN  = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          i_req_tvalid,
    output logic [NREQ-1:0]          o_req_tready,
    input  logic [NREQ*DLEN-1:0]     i_req_tdata,
    input  logic [NREQ-1:0]          i_req_tlast,
    output logic                     o_wr_tvalid,
    input  logic                     i_wr_tready,
    output logic [DLEN-1:0]          o_wr_tdata,
    output logic [$clog2(NREQ)-1:0]  o_grant_id,
    output logic                     o_busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       o_beat_cnt
`endif
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST + 1);

    state_t        state, state_nxt;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [CW-1:0] beat_cnt;
    logic          xfer;
    logic          done;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (i_req_tvalid),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The counter is held at zero throughout IDLE, which clears it on entry to GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= IW'(NREQ - 1);
            beat_cnt   <= '0;
        end else if (state == IDLE) begin
            beat_cnt <= '0;
            if (pick_any) begin
                grant_id <= pick_idx;
            end
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (done) begin
                last_grant <= grant_id;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        o_busy       = 1'b0;
        o_wr_tvalid  = 1'b0;
        o_wr_tdata   = '0;
        o_req_tready = '0;
        xfer         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                o_busy                 = 1'b1;
                o_wr_tvalid            = i_req_tvalid[grant_id];
                o_wr_tdata             = i_req_tdata[grant_id*DLEN +: DLEN];
                o_req_tready[grant_id] = i_wr_tready;
                xfer                   = i_req_tvalid[grant_id] & i_wr_tready;
                // beat_cnt still holds the pre-transfer count, so BURST-1 means this beat is the last.
                done = xfer & (i_req_tlast[grant_id] | (beat_cnt == CW'(BURST - 1)));
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_grant_id = grant_id;

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_beat_cnt <= '0;
        end else if (xfer) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (grant_id == IW'(k) && o_beat_cnt[k*16 +: 16] != STAT_MAX) begin
                    o_beat_cnt[k*16 +: 16] <= o_beat_cnt[k*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
